// File: rtl/imm_encoder_if.sv
// Request/result bus of the RV32I instruction assembler.
// The requester drives the request fields and out_ready; the encoder drives in_ready and the result.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_format;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_error;

    modport master (
        output in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_error
    );

    modport slave (
        input  in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_error
    );
endinterface

// File: rtl/imm_encoder.sv
// RV32I instruction assembler: packs immediate + register/opcode fields into an
// I/S/B/U/J instruction word, flags unrepresentable immediates (result becomes a NOP).
// Two-stage valid/ready pipeline with saturating delivered/error counters.
module imm_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    imm_encoder_if.slave       bus,
    output logic [COUNT_W-1:0] enc_count,
    output logic [COUNT_W-1:0] err_count
);
    localparam logic [2:0]  FMT_U = 3'b000;
    localparam logic [2:0]  FMT_I = 3'b001;
    localparam logic [2:0]  FMT_S = 3'b010;
    localparam logic [2:0]  FMT_B = 3'b011;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // Stage-1 registered request
    logic               vld_p1;
    logic [2:0]         fmt_p1;
    logic [6:0]         opcode_p1;
    logic [4:0]         rd_p1;
    logic [4:0]         rs1_p1;
    logic [4:0]         rs2_p1;
    logic [2:0]         funct3_p1;
    logic signed [31:0] imm_p1;

    // Stage-2 registered result
    logic               vld_p2;
    logic [31:0]        instr_p2;
    logic               err_p2;

    logic               s2_adv;
    logic               s1_adv;
    logic               accept;
    logic               deliver;
    logic [31:0]        enc_instr;
    logic               enc_err;

    // Immediate cannot be expressed in the selected format
    function automatic logic imm_bad(input logic [2:0] fmt, input logic signed [31:0] imm);
        logic bad;
        if (fmt[2])
            bad = (imm[31:20] != {12{imm[31]}}) || imm[0];
        else if (fmt == FMT_U)
            bad = (imm[11:0] != 12'h000);
        else if (fmt == FMT_B)
            bad = (imm[31:12] != {20{imm[31]}}) || imm[0];
        else
            bad = (imm[31:11] != {21{imm[31]}});
        return bad;
    endfunction

    // Scatter the immediate bits into their instruction positions
    function automatic logic [31:0] encode(
        input logic [2:0]         fmt,
        input logic [6:0]         op,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic [2:0]         f3,
        input logic signed [31:0] imm
    );
        logic [31:0] w;
        if (fmt[2])
            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        else begin
            case (fmt)
                FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
                FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                default: w = {imm[31:12], rd, op};
            endcase
        end
        return w;
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (&c) ? c : c + COUNT_W'(1);
    endfunction

    assign s2_adv       = !vld_p2 || bus.out_ready;
    assign s1_adv       = vld_p1 && s2_adv;
    assign bus.in_ready = !vld_p1 || s2_adv;
    assign accept       = bus.in_valid && bus.in_ready;
    assign deliver      = vld_p2 && bus.out_ready;

    assign bus.out_valid = vld_p2;
    assign bus.out_instr = instr_p2;
    assign bus.out_error = err_p2;

    // Stage-1 occupancy: filled on accept, emptied when its content moves on
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            vld_p1 <= 1'b0;
        else if (accept)
            vld_p1 <= 1'b1;
        else if (s1_adv)
            vld_p1 <= 1'b0;
    end

    // Stage-1 request fields captured on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            fmt_p1    <= bus.in_format;
            opcode_p1 <= bus.in_opcode;
            rd_p1     <= bus.in_rd;
            rs1_p1    <= bus.in_rs1;
            rs2_p1    <= bus.in_rs2;
            funct3_p1 <= bus.in_funct3;
            imm_p1    <= bus.in_imm;
        end
    end

    // Encode and range-check the stage-1 request
    always_comb begin
        enc_err   = imm_bad(fmt_p1, imm_p1);
        enc_instr = NOP;
        if (!enc_err)
            enc_instr = encode(fmt_p1, opcode_p1, rd_p1, rs1_p1, rs2_p1, funct3_p1, imm_p1);
    end

    // ---- stage 1 -> stage 2 boundary ----
    // Result register: loads when free or being drained, otherwise holds steady
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2   <= 1'b0;
            instr_p2 <= 32'h0;
            err_p2   <= 1'b0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                instr_p2 <= enc_instr;
                err_p2   <= enc_err;
            end
        end
    end

    // Saturating statistics on each delivered result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (deliver) begin
            enc_count <= sat_inc(enc_count);
            if (err_p2)
                err_count <= sat_inc(err_count);
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: vector table for encodings and range errors,
// plus backpressure, counter saturation (second instance, COUNT_W=2) and reset sequences.
module tb_imm_encoder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [15:0] enc_count, err_count;
    logic [1:0]  enc_count_s, err_count_s;

    int n_pass = 0;
    int n_total = 0;

    imm_encoder_if bus ();
    imm_encoder_if bus_s ();

    always #5 clk = ~clk;

    imm_encoder #(.COUNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .enc_count(enc_count), .err_count(err_count)
    );

    // Saturation instance sees exactly the same traffic as the main one
    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.in_format = bus.in_format;
    assign bus_s.in_opcode = bus.in_opcode;
    assign bus_s.in_rd     = bus.in_rd;
    assign bus_s.in_rs1    = bus.in_rs1;
    assign bus_s.in_rs2    = bus.in_rs2;
    assign bus_s.in_funct3 = bus.in_funct3;
    assign bus_s.in_imm    = bus.in_imm;
    assign bus_s.out_ready = bus.out_ready;

    imm_encoder #(.COUNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(bus_s), .enc_count(enc_count_s), .err_count(err_count_s)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.in_format = v.fmt;
        bus.in_opcode = v.op;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_funct3 = v.f3;
        bus.in_imm    = v.imm;
    endtask

    function automatic vec_t addi(input int k);
        vec_t v;
        v = '{3'b001, 7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 32'(k), 32'h0, 1'b0};
        v.exp_instr = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
        return v;
    endfunction

    // Global guard so the run always terminates
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t br [3];
        logic [31:0] held;
        logic [31:0] got [$];
        int got_cyc [$];
        int acc;
        int exp_err_n;

        vecs[0]  = '{3'b001, 7'h13, 5'd1, 5'd2,  5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0};
        vecs[1]  = '{3'b010, 7'h23, 5'd0, 5'd10, 5'd5, 3'd2, 32'h0000_0008, 32'h0055_2423, 1'b0};
        vecs[2]  = '{3'b011, 7'h63, 5'd0, 5'd0,  5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
        vecs[3]  = '{3'b100, 7'h6F, 5'd1, 5'd0,  5'd0, 3'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0};
        vecs[4]  = '{3'b000, 7'h37, 5'd3, 5'd0,  5'd0, 3'd0, 32'h1234_5000, 32'h1234_51B7, 1'b0};
        vecs[5]  = '{3'b010, 7'h23, 5'd0, 5'd1,  5'd2, 3'd2, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0};
        vecs[6]  = '{3'b001, 7'h13, 5'd0, 5'd0,  5'd0, 3'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0};
        vecs[7]  = '{3'b011, 7'h63, 5'd0, 5'd0,  5'd0, 3'd0, 32'hFFFF_F000, 32'h8000_0063, 1'b0};
        vecs[8]  = '{3'b001, 7'h13, 5'd1, 5'd2,  5'd0, 3'd0, 32'h0000_0800, 32'h0000_0013, 1'b1};
        vecs[9]  = '{3'b011, 7'h63, 5'd0, 5'd1,  5'd2, 3'd0, 32'h0000_0003, 32'h0000_0013, 1'b1};
        vecs[10] = '{3'b000, 7'h37, 5'd3, 5'd0,  5'd0, 3'd0, 32'h0000_0001, 32'h0000_0013, 1'b1};
        vecs[11] = '{3'b110, 7'h6F, 5'd1, 5'd0,  5'd0, 3'd0, 32'h0010_0000, 32'h0000_0013, 1'b1};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("init_out_valid", 32'(bus.out_valid), 32'd0);
        chk("init_in_ready", 32'(bus.in_ready), 32'd1);
        chk("init_out_instr", bus.out_instr, 32'h0);

        // Table: one request at a time, checking latency, value and counters
        exp_err_n = 0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("v%0d_enc_count", i), 32'(enc_count), 32'(i));
            chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(exp_err_n));
            chk($sformatf("v%0d_sat_enc", i), 32'(enc_count_s), 32'((i < 3) ? i : 3));
            drive(vecs[i]);
            bus.in_valid = 1'b1;
            chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d_early_valid", i), 32'(bus.out_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("v%0d_instr", i), bus.out_instr, vecs[i].exp_instr);
            chk($sformatf("v%0d_error", i), 32'(bus.out_error), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err) exp_err_n++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("table_enc_count", 32'(enc_count), 32'd12);
        chk("table_err_count", 32'(err_count), 32'd4);
        chk("sat_enc_count", 32'(enc_count_s), 32'd3);
        chk("sat_err_count", 32'(err_count_s), 32'd3);

        // Backpressure: 3 requests offered for 5 cycles with the consumer stalled
        for (int k = 0; k < 3; k++) br[k] = addi(k + 1);
        bus.out_ready = 1'b0;
        acc = 0;
        held = 32'h0;
        for (int c = 0; c < 5; c++) begin
            if (acc < 3) begin
                drive(br[acc]);
                bus.in_valid = 1'b1;
            end
            if (bus.out_valid && c == 2) held = bus.out_instr;
            @(posedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(negedge clk);
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_held_instr", bus.out_instr, held);
        chk("bp_first_instr", bus.out_instr, br[0].exp_instr);

        // Release: the third request enters while the first two drain
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && got.size() < 3; c++) begin
            if (acc < 3) drive(br[acc]);
            bus.in_valid = (acc < 3);
            if (bus.out_valid) begin
                got.push_back(bus.out_instr);
                got_cyc.push_back(c);
            end
            @(posedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("rel_count", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) begin
                chk($sformatf("rel_instr%0d", k), got[k], br[k].exp_instr);
                chk($sformatf("rel_cycle%0d", k), 32'(got_cyc[k]), 32'(k));
            end
        end
        @(negedge clk);
        chk("bp_enc_count", 32'(enc_count), 32'd15);
        chk("sat_enc_hold", 32'(enc_count_s), 32'd3);
        chk("sat_err_hold", 32'(err_count_s), 32'd3);

        // Reset with both stages occupied
        bus.out_ready = 1'b0;
        drive(br[0]);
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_enc_count", 32'(enc_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_out_error", 32'(bus.out_error), 32'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_no_ghost", 32'(bus.out_valid), 32'd0);
        end
        chk("rst_counts_hold", 32'(enc_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
